// File: rtl/uart_fifo_if.sv
// uart_fifo_if: push/pop handshake, data and status bundle for uart_fifo.
// master = host/controller side, slave = the FIFO itself.
interface uart_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr_i;
  logic              push_i;
  logic [DATA_W-1:0] data_i;
  logic              pop_i;
  logic [DATA_W-1:0] data_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output clr_i,
    output push_i,
    output data_i,
    output pop_i,
    input  data_o,
    input  full_o,
    input  empty_o,
    input  almost_full_o,
    input  almost_empty_o,
    input  count_o,
    input  overflow_o,
    input  underflow_o
  );

  modport slave (
    input  clr_i,
    input  push_i,
    input  data_i,
    input  pop_i,
    output data_o,
    output full_o,
    output empty_o,
    output almost_full_o,
    output almost_empty_o,
    output count_o,
    output overflow_o,
    output underflow_o
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: FWFT character FIFO with registered flags and sticky errors.
// Ports: clk_i, rst_ni (async active-low), bus (uart_fifo_if.slave).
module uart_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  uart_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C   = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] CNT1   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR1 = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  logic push_ok;
  logic pop_ok;

  // A push into a full FIFO is fine when a pop frees the slot
  // in the same cycle; a pop never bypasses an empty FIFO.
  assign push_ok = bus.push_i && !bus.clr_i &&
                   (!full_q || bus.pop_i);
  assign pop_ok  = bus.pop_i && !bus.clr_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    unique case (1'b1)
      bus.clr_i: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
      end
      default: begin
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR1;
        if (push_ok && !pop_ok) count_d = count_q + CNT1;
        if (pop_ok && !push_ok) count_d = count_q - CNT1;
        if (bus.push_i && !push_ok) ovf_d = 1'b1;
        if (bus.pop_i && !pop_ok)   udf_d = 1'b1;
      end
    endcase
  end

  // Flags come from the next count so they track count_o exactly.
  always_comb begin
    full_d  = (count_d == FULL_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.data_i;
  end

  assign bus.data_o = empty_q ? '0 : mem_q[rd_ptr_q];

  assign bus.full_o         = full_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.count_o        = count_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed checks of uart_fifo against hand-computed values.
// Drives bus just after each rising edge, samples before the next one.
module tb_uart_fifo;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  uart_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_fifo u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr_i  = 1'b0;
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    bus.data_i = '0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.push_i = 1'b1;
    bus.data_i = d;
    cyc();
    idle();
  endtask

  task automatic pop();
    bus.pop_i = 1'b1;
    cyc();
    idle();
  endtask

  task automatic pushpop(input logic [7:0] d);
    bus.push_i = 1'b1;
    bus.pop_i  = 1'b1;
    bus.data_i = d;
    cyc();
    idle();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"},   32'(bus.count_o), 0);
    chk({tag, "_empty"}, 32'(bus.empty_o), 1);
    chk({tag, "_ae"},    32'(bus.almost_empty_o), 1);
    chk({tag, "_full"},  32'(bus.full_o), 0);
    chk({tag, "_af"},    32'(bus.almost_full_o), 0);
    chk({tag, "_ovf"},   32'(bus.overflow_o), 0);
    chk({tag, "_udf"},   32'(bus.underflow_o), 0);
    chk({tag, "_data"},  32'(bus.data_o), 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    #12;
    chk_reset("rst");
    rst_n = 1'b1;
    cyc();
    chk_reset("rst_rel");

    push(8'h41);
    push(8'h42);
    push(8'h43);
    chk("p3_cnt",  32'(bus.count_o), 3);
    chk("p3_data", 32'(bus.data_o), 32'h41);
    pop();
    chk("pop1", 32'(bus.data_o), 32'h42);
    pop();
    chk("pop2", 32'(bus.data_o), 32'h43);
    pop();
    chk("pop3", 32'(bus.data_o), 0);
    chk("pop3_empty", 32'(bus.empty_o), 1);
    chk("pop3_udf", 32'(bus.underflow_o), 0);

    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_cnt", 32'(bus.count_o), 32'(i + 1));
      chk("fill_af", 32'(bus.almost_full_o),
          32'((i + 1) >= 12));
      chk("fill_ae", 32'(bus.almost_empty_o),
          32'((i + 1) <= 4));
    end
    chk("fill_full", 32'(bus.full_o), 1);
    chk("fill_head", 32'(bus.data_o), 0);
    push(8'hAA);
    chk("ovf_flag", 32'(bus.overflow_o), 1);
    chk("ovf_cnt", 32'(bus.count_o), 16);
    pop();
    chk("ovf_pop", 32'(bus.data_o), 1);
    chk("ovf_pop_full", 32'(bus.full_o), 0);

    push(8'h10);
    chk("pp_full", 32'(bus.full_o), 1);
    pushpop(8'h55);
    chk("ppf_cnt", 32'(bus.count_o), 16);
    chk("ppf_full", 32'(bus.full_o), 1);
    chk("ppf_head", 32'(bus.data_o), 2);
    for (int k = 0; k < 16; k++) begin
      chk("drain", 32'(bus.data_o),
          (k < 15) ? 32'(k + 2) : 32'h55);
      pop();
    end
    chk("drain_empty", 32'(bus.empty_o), 1);
    chk("drain_udf", 32'(bus.underflow_o), 0);

    pushpop(8'h7E);
    chk("ppe_cnt",  32'(bus.count_o), 1);
    chk("ppe_data", 32'(bus.data_o), 32'h7E);
    chk("ppe_udf",  32'(bus.underflow_o), 1);
    pop();
    chk("ppe_empty", 32'(bus.empty_o), 1);

    for (int i = 0; i < 5; i++) push(8'(i));
    for (int i = 0; i < 40; i++) begin
      chk("wrap_data", 32'(bus.data_o), 32'(i));
      pushpop(8'(i + 5));
      chk("wrap_cnt", 32'(bus.count_o), 5);
    end

    push(8'hF0);
    push(8'hF1);
    chk("clr_pre_cnt", 32'(bus.count_o), 7);
    chk("clr_pre_ovf", 32'(bus.overflow_o), 1);
    bus.clr_i  = 1'b1;
    bus.push_i = 1'b1;
    bus.data_i = 8'h99;
    cyc();
    idle();
    chk_reset("clr");
    bus.clr_i = 1'b1;
    bus.pop_i = 1'b1;
    cyc();
    idle();
    chk("clr_pop_udf", 32'(bus.underflow_o), 0);
    chk("clr_pop_cnt", 32'(bus.count_o), 0);

    for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
    chk("ar_pre_cnt", 32'(bus.count_o), 9);
    chk("ar_pre_data", 32'(bus.data_o), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_reset("arst_rel");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous first-word-fall-through (FWFT) FIFO that buffers UART characters between the host and `uart_controller`. The Tx instance sits upstream of the controller: `data_o` drives `tx_data_i`, `tx_fifo_pop_o` drives `pop_i`, and `!empty_o` drives `tx_fifo_en_i`. The Rx instance sits downstream: `rx_fifo_push_o` drives `push_i` and `rx_data_o` drives `data_i`. Status flags are registered, and error flags are sticky for host polling.

## Interface
- `DATA_W`, 8, width of one stored character (matches `MAX_UART_DATA_W`)
- `DEPTH`, 16, number of entries; power of two, ≥ 4
- `ADDR_W`, 4, pointer width = $clog2(DEPTH)
- `AF_THRESH`, 12, `almost_full_o` asserts when count ≥ this
- `AE_THRESH`, 4, `almost_empty_o` asserts when count ≤ this

Ports (clock and reset first):
- `clk_i`  in  1  single clock; all logic on its rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `clr_i`  in  1  synchronous flush; empties the FIFO and clears sticky errors
- `push_i`  in  1  write request; one character per cycle
- `data_i`  in  DATA_W  write data, sampled when the push is accepted
- `pop_i`  in  1  read request; removes the head entry
- `data_o`  out  DATA_W  head entry (FWFT); 0 when `empty_o`=1
- `full_o`  out  1  count == DEPTH
- `empty_o`  out  1  count == 0
- `almost_full_o`  out  1  count ≥ AF_THRESH
- `almost_empty_o`  out  1  count ≤ AE_THRESH
- `count_o`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `overflow_o`  out  1  sticky: a push was rejected
- `underflow_o`  out  1  sticky: a pop was rejected

## Operation
**Storage**
- DEPTH×DATA_W register array, not reset.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_W bits wide and wrap naturally modulo DEPTH.
- Occupancy is held in a separate ADDR_W+1-bit counter.

**Acceptance rules** (priority order)
1. `clr_i`=1: pointers → 0, count → 0, overflow/underflow → 0. Any push or pop in the same cycle is ignored and does not set an error flag.
2. Push when count < DEPTH: accepted; mem[wr_ptr] ← data_i; wr_ptr+1.
3. Push when full, with `pop_i`=1: accepted; the slot freed by the pop is reused; count stays at DEPTH.
4. Push when full, with `pop_i`=0: rejected; `overflow_o` ← 1.
5. Pop when count > 0: accepted; rd_ptr+1.
6. Pop when empty: rejected; `underflow_o` ← 1. This holds even if `push_i`=1 in the same cycle (no bypass): the push is accepted and count becomes 1.

**Count update**
- +1 for push only, −1 for pop only, unchanged for both or neither.
- Never leaves the range 0..DEPTH.

**Outputs**
- `data_o` = mem[rd_ptr] when not empty, else all zeros.
- All flags and `count_o` are registers derived from the next-state count, so they are consistent with `count_o` on every cycle.
- Sticky errors clear only on `clr_i` or reset.

**Reset** (`rst_ni`=0, asynchronous): pointers 0, count 0.
- `empty_o`=1, `almost_empty_o`=1.
- `full_o`=0, `almost_full_o`=0.
- `overflow_o`=0, `underflow_o`=0.
- `data_o`=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Push accepted at edge N → after edge N: `empty_o`=0 and `data_o` = pushed value. Write-to-read latency is 1 cycle.
- Pop accepted at edge N → after edge N: `data_o` shows the next entry, or 0 if the FIFO is now empty.
- `pop_i` may be held for one cycle per character; the Tx single-cycle `tx_fifo_pop_o` pulse removes exactly one entry.
- `data_o` is combinational from the registered `rd_ptr` and memory; there is no extra output register.
- Flags change only on clock edges, except on asynchronous reset.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- **Reset, then 3 pushes:** reset, push 0x41, 0x42, 0x43 → `count_o`=3, `data_o`=0x41. Pop three times → `data_o` 0x42, 0x43, then 0 with `empty_o`=1.
- **Fill and overflow:** push 16 values 0x00..0x0F → `full_o`=1, `almost_full_o` asserted from count 12. Push 0xAA → rejected, `overflow_o`=1. Pop → `data_o`=0x01.
- **Push+pop while full:** with count=16, push 0x55 and pop in the same cycle → count stays 16. After 16 further pops, the last value out is 0x55.
- **Push+pop while empty:** on an empty FIFO, push 0x7E and pop in the same cycle → `count_o`=1, `data_o`=0x7E, `underflow_o`=1.
- **Wrap-around:** run 40 push/pop pairs with values 0..39 at steady occupancy 5 → output order is exactly 0..39 and `count_o` stays 5.
- **Flush and async reset:** at count=7 with `overflow_o`=1, assert `clr_i` alongside a push → count 0, flags cleared, no error set. At count=9, drop `rst_ni` between clock edges → `empty_o`=1 immediately.
